// File: rtl/pdp8_xfer_pkg.sv
// Shared types and constants for the register transfer sequencer.
package pdp8_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        CAPTURE = 3'd2,
        STROBE  = 3'd3,
        DONE    = 3'd4
    } xfer_state_e;

    // Bus select encoding
    localparam logic BUS1 = 1'b0;
    localparam logic BUS2 = 1'b1;

    // Requester identifiers
    localparam logic REQ_CPU   = 1'b0;
    localparam logic REQ_PANEL = 1'b1;

    // One-hot requester vector from a requester id
    function automatic logic [1:0] req_onehot(input logic id);
        return (id == REQ_PANEL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_xfer_seq_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the requester not served last.
module rr_arb2
    import pdp8_xfer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c
);

    logic prio_q;
    logic winner_c;

    // Pick the winner: the preferred requester on a tie, otherwise whoever asks
    always_comb begin
        winner_c = REQ_CPU;
        if (req == 2'b11) begin
            winner_c = prio_q;
        end else if (req[REQ_PANEL]) begin
            winner_c = REQ_PANEL;
        end
    end

    assign grant_c = (req == 2'b00) ? 2'b00 : req_onehot(winner_c);

    // Preference flips away from each served (or rejected) winner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= REQ_CPU;
        end else if (advance) begin
            prio_q <= ~winner_c;
        end
    end

endmodule

// File: rtl/reg_xfer_seq.sv
// Sequences one register-to-register transfer at a time through the latch
// registers, shared between the major-state control and the front panel.
module reg_xfer_seq
    import pdp8_xfer_pkg::*;
#(
    parameter int unsigned NREG   = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned IW     = $clog2(NREG)
) (
    input  logic            SYSCLK,
    input  logic            RESET_N,
    input  logic [1:0]      req,
    input  logic [IW-1:0]   src0,
    input  logic [IW-1:0]   src1,
    input  logic [IW-1:0]   dst0,
    input  logic [IW-1:0]   dst1,
    input  logic            bus0,
    input  logic            bus1,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [1:0]      err,
    output logic            busy,
    output logic [NREG-1:0] oe1,
    output logic [NREG-1:0] oe2,
    output logic [NREG-1:0] hold,
    output logic [NREG-1:0] latch
);

    localparam int unsigned   CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [NREG-1:0] ONE       = {{(NREG-1){1'b0}}, 1'b1};

    xfer_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   src_q, dst_q;
    logic            bus_q;
    logic [1:0]      win_q;

    logic [1:0]      grant_c;
    logic            win_id_c;
    logic [IW-1:0]   sel_src_c, sel_dst_c;
    logic            sel_bus_c;
    logic            sel_ok_c, arb_c, accept_c, reject_c;
    logic [NREG-1:0] src_oh_c, dst_oh_c;

    logic [1:0]      gnt_d, done_d, err_d;
    logic            busy_d;
    logic [NREG-1:0] oe1_d, oe2_d, hold_d, latch_d;

    rr_arb2 u_arb (
        .clk     (SYSCLK),
        .rst_n   (RESET_N),
        .req     (req),
        .advance (arb_c),
        .grant_c (grant_c)
    );

    // Fields of the arbitration winner and their range check
    assign win_id_c  = grant_c[REQ_PANEL];
    assign sel_src_c = win_id_c ? src1 : src0;
    assign sel_dst_c = win_id_c ? dst1 : dst0;
    assign sel_bus_c = win_id_c ? bus1 : bus0;
    assign sel_ok_c  = (32'(sel_src_c) < NREG) && (32'(sel_dst_c) < NREG);
    assign arb_c     = (state_q == IDLE) && (req != 2'b00);
    assign accept_c  = arb_c && sel_ok_c;
    assign reject_c  = arb_c && !sel_ok_c;

    assign src_oh_c  = ONE << src_q;
    assign dst_oh_c  = ONE << dst_q;

    // State register, settle counter and captured transfer fields
    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            bus_q   <= BUS1;
            win_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if ((state_q == DRIVE) && (state_d == DRIVE)) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
            if (accept_c) begin
                src_q <= sel_src_c;
                dst_q <= sel_dst_c;
                bus_q <= sel_bus_c;
                win_q <= grant_c;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = DRIVE;
            DRIVE:   if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
            CAPTURE: state_d = STROBE;
            STROBE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the current phase
    always_comb begin
        gnt_d   = 2'b00;
        err_d   = 2'b00;
        done_d  = 2'b00;
        busy_d  = accept_c || (state_q != IDLE);
        oe1_d   = '0;
        oe2_d   = '0;
        hold_d  = '1;
        latch_d = '0;
        if (accept_c) gnt_d = grant_c;
        if (reject_c) err_d = grant_c;
        if (state_q inside {DRIVE, CAPTURE, STROBE}) begin
            if (bus_q == BUS2) begin
                oe2_d = src_oh_c;
            end else begin
                oe1_d = src_oh_c;
            end
        end
        if (state_q inside {CAPTURE, STROBE}) hold_d = ~dst_oh_c;
        if (state_q == STROBE) latch_d = dst_oh_c;
        if (state_q == DONE) done_d = win_q;
    end

    // Output registers; reset releases the bus and freezes every holdreg
    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            gnt   <= 2'b00;
            err   <= 2'b00;
            done  <= 2'b00;
            busy  <= 1'b0;
            oe1   <= '0;
            oe2   <= '0;
            hold  <= '1;
            latch <= '0;
        end else begin
            gnt   <= gnt_d;
            err   <= err_d;
            done  <= done_d;
            busy  <= busy_d;
            oe1   <= oe1_d;
            oe2   <= oe2_d;
            hold  <= hold_d;
            latch <= latch_d;
        end
    end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed and randomized checks of reg_xfer_seq. u_s1 runs SETTLE=1 for the
// directed steps; u_s3 runs SETTLE=3 under random traffic against a
// transaction-window model.
module tb_reg_xfer_seq;

    localparam int S3 = 3;

    logic SYSCLK = 1'b0;
    logic RESET_N;

    logic [1:0] a_req, a_gnt, a_done, a_err;
    logic [3:0] a_src0, a_src1, a_dst0, a_dst1;
    logic       a_bus0, a_bus1, a_busy;
    logic [7:0] a_oe1, a_oe2, a_hold, a_latch;

    logic [1:0] b_req, b_gnt, b_done, b_err;
    logic [3:0] b_src0, b_src1, b_dst0, b_dst1;
    logic       b_bus0, b_bus1, b_busy;
    logic [7:0] b_oe1, b_oe2, b_hold, b_latch;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 SYSCLK = ~SYSCLK;

    reg_xfer_seq #(.NREG(8), .SETTLE(1), .IW(4)) u_s1 (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .req(a_req),
        .src0(a_src0), .src1(a_src1), .dst0(a_dst0), .dst1(a_dst1),
        .bus0(a_bus0), .bus1(a_bus1), .gnt(a_gnt), .done(a_done), .err(a_err),
        .busy(a_busy), .oe1(a_oe1), .oe2(a_oe2), .hold(a_hold), .latch(a_latch)
    );

    reg_xfer_seq #(.NREG(8), .SETTLE(S3), .IW(4)) u_s3 (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .req(b_req),
        .src0(b_src0), .src1(b_src1), .dst0(b_dst0), .dst1(b_dst1),
        .bus0(b_bus0), .bus1(b_bus1), .gnt(b_gnt), .done(b_done), .err(b_err),
        .busy(b_busy), .oe1(b_oe1), .oe2(b_oe2), .hold(b_hold), .latch(b_latch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYSCLK);
            #1;
        end
    endtask

    function automatic logic [3:0] pick_idx();
        if ($urandom_range(0, 9) == 0) return 4'(8 + $urandom_range(0, 7));
        return 4'($urandom_range(0, 7));
    endfunction

    // Random-phase model state
    int          m_n, mp, w, ws, wd, wb, d, m_w, m_src, m_dst, m_bus;
    logic [31:0] e_gnt, e_err, e_done, e_busy, e_oe1, e_oe2, e_hold, e_latch;
    logic [3:0]  rs, rd;
    logic        rb;

    initial begin
        RESET_N = 1'b0;
        a_req = 2'b00; a_src0 = '0; a_src1 = '0; a_dst0 = '0; a_dst1 = '0; a_bus0 = 0; a_bus1 = 0;
        b_req = 2'b00; b_src0 = '0; b_src1 = '0; b_dst0 = '0; b_dst1 = '0; b_bus0 = 0; b_bus1 = 0;

        // 1: reset state
        tick(2);
        check("rst hold", 32'(a_hold), 'hFF);
        check("rst oe1", 32'(a_oe1), 0);
        check("rst oe2", 32'(a_oe2), 0);
        check("rst latch", 32'(a_latch), 0);
        check("rst busy", 32'(a_busy), 0);
        check("rst gnt", 32'(a_gnt), 0);
        check("rst done", 32'(a_done), 0);
        RESET_N = 1'b1;
        tick(1);

        // 2: single transfer 2 -> 5 on bus 1
        a_src0 = 4'd2; a_dst0 = 4'd5; a_bus0 = 1'b0; a_req = 2'b01;
        tick(1);
        check("t2 gnt N", 32'(a_gnt), 1);
        check("t2 busy N", 32'(a_busy), 1);
        check("t2 oe1 N", 32'(a_oe1), 0);
        tick(1);
        check("t2 oe1 N+1", 32'(a_oe1), 'h04);
        check("t2 hold N+1", 32'(a_hold), 'hFF);
        check("t2 gnt N+1", 32'(a_gnt), 0);
        tick(1);
        check("t2 oe1 N+2", 32'(a_oe1), 'h04);
        check("t2 hold N+2", 32'(a_hold), 'hDF);
        check("t2 latch N+2", 32'(a_latch), 0);
        tick(1);
        check("t2 oe1 N+3", 32'(a_oe1), 'h04);
        check("t2 hold N+3", 32'(a_hold), 'hDF);
        check("t2 latch N+3", 32'(a_latch), 'h20);
        check("t2 done N+3", 32'(a_done), 0);
        tick(1);
        check("t2 done N+4", 32'(a_done), 1);
        check("t2 oe1 N+4", 32'(a_oe1), 0);
        check("t2 hold N+4", 32'(a_hold), 'hFF);
        check("t2 latch N+4", 32'(a_latch), 0);
        check("t2 busy N+4", 32'(a_busy), 1);
        a_req = 2'b00;
        tick(1);
        check("t2 busy N+5", 32'(a_busy), 0);
        check("t2 gnt N+5", 32'(a_gnt), 0);

        // 3: simultaneous requests after reset
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        a_src0 = 4'd1; a_dst0 = 4'd3; a_bus0 = 1'b0;
        a_src1 = 4'd4; a_dst1 = 4'd6; a_bus1 = 1'b1;
        a_req = 2'b11;
        tick(1);
        check("t3 first gnt", 32'(a_gnt), 'b01);
        tick(4);
        check("t3 first done", 32'(a_done), 'b01);
        tick(1);
        check("t3 second gnt", 32'(a_gnt), 'b10);
        tick(1);
        check("t3 second oe2", 32'(a_oe2), 'h10);
        check("t3 second oe1", 32'(a_oe1), 0);
        tick(3);
        check("t3 second done", 32'(a_done), 'b10);
        a_req = 2'b01;
        tick(1);
        check("t3 third gnt", 32'(a_gnt), 'b01);
        tick(4);
        check("t3 third done", 32'(a_done), 'b01);
        a_req = 2'b00;
        tick(1);

        // 4: out-of-range source, then a legal src==dst transfer
        a_src1 = 4'd9; a_dst1 = 4'd2; a_req = 2'b10;
        tick(1);
        check("t4 err", 32'(a_err), 'b10);
        check("t4 gnt", 32'(a_gnt), 0);
        check("t4 busy", 32'(a_busy), 0);
        check("t4 oe", 32'(a_oe1 | a_oe2), 0);
        a_req = 2'b01; a_src0 = 4'd3; a_dst0 = 4'd3; a_bus0 = 1'b0;
        tick(1);
        check("t4 next gnt", 32'(a_gnt), 'b01);
        check("t4 next err", 32'(a_err), 0);
        check("t4 latch idle", 32'(a_latch), 0);
        tick(1);
        check("t4 self oe1", 32'(a_oe1), 'h08);
        tick(2);
        check("t4 self latch", 32'(a_latch), 'h08);
        check("t4 self hold", 32'(a_hold), 'hF7);
        tick(1);
        check("t4 self done", 32'(a_done), 'b01);
        a_req = 2'b00;
        tick(1);

        // 5: reset while the strobe is on the latch output
        a_src0 = 4'd6; a_dst0 = 4'd1; a_bus0 = 1'b1; a_req = 2'b01;
        tick(1);
        check("t5 gnt", 32'(a_gnt), 'b01);
        tick(3);
        check("t5 latch", 32'(a_latch), 'h02);
        check("t5 oe2", 32'(a_oe2), 'h40);
        check("t5 hold", 32'(a_hold), 'hFD);
        RESET_N = 1'b0;
        a_req = 2'b00;
        tick(1);
        check("t5 rst latch", 32'(a_latch), 0);
        check("t5 rst oe", 32'(a_oe1 | a_oe2), 0);
        check("t5 rst hold", 32'(a_hold), 'hFF);
        check("t5 rst done", 32'(a_done), 0);
        check("t5 rst busy", 32'(a_busy), 0);
        RESET_N = 1'b1;
        tick(1);
        check("t5 no done 1", 32'(a_done), 0);
        tick(1);
        check("t5 no done 2", 32'(a_done), 0);
        a_src0 = 4'd0; a_dst0 = 4'd7; a_bus0 = 1'b0; a_req = 2'b01;
        tick(1);
        check("t5 idle gnt", 32'(a_gnt), 'b01);
        tick(4);
        check("t5 idle done", 32'(a_done), 'b01);
        a_req = 2'b00;
        tick(1);

        // 6: random traffic on the SETTLE=3 instance
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        m_n = -1000; mp = 0; m_w = 0; m_src = 0; m_dst = 0; m_bus = 0;
        e_done = 0; e_err = 0;
        for (int t = 0; t < 600; t++) begin
            // requesters hold until done/err, otherwise raise at random
            for (int i = 0; i < 2; i++) begin
                if (b_req[i] && (e_done[i] || e_err[i])) begin
                    b_req[i] = 1'b0;
                end else if (!b_req[i] && $urandom_range(0, 2) == 0) begin
                    rs = pick_idx();
                    rd = pick_idx();
                    rb = ($urandom_range(0, 3) != 0);
                    if (i == 0) begin
                        b_src0 = rs; b_dst0 = rd; b_bus0 = rb;
                    end else begin
                        b_src1 = rs; b_dst1 = rd; b_bus1 = rb;
                    end
                    b_req[i] = 1'b1;
                end
            end
            tick(1);

            // the edge just taken: arbitrate if the path was free
            e_gnt = 0;
            e_err = 0;
            if ((t + 1 - m_n >= S3 + 4) && (b_req != 2'b00)) begin
                w  = (b_req == 2'b11) ? mp : (b_req[1] ? 1 : 0);
                mp = 1 - w;
                ws = (w == 1) ? int'(b_src1) : int'(b_src0);
                wd = (w == 1) ? int'(b_dst1) : int'(b_dst0);
                wb = (w == 1) ? int'(b_bus1) : int'(b_bus0);
                if (ws < 8 && wd < 8) begin
                    m_n = t + 1; m_w = w; m_src = ws; m_dst = wd; m_bus = wb;
                    e_gnt = 32'd1 << w;
                end else begin
                    e_err = 32'd1 << w;
                end
            end

            // expected outputs from the position inside the transfer window
            d       = t + 1 - m_n;
            e_busy  = (d >= 0 && d <= S3 + 3) ? 1 : 0;
            e_oe1   = (d >= 1 && d <= S3 + 2 && m_bus == 0) ? (32'd1 << m_src) : 0;
            e_oe2   = (d >= 1 && d <= S3 + 2 && m_bus == 1) ? (32'd1 << m_src) : 0;
            e_hold  = (d >= S3 + 1 && d <= S3 + 2) ? ('hFF & ~(32'd1 << m_dst)) : 'hFF;
            e_latch = (d == S3 + 2) ? (32'd1 << m_dst) : 0;
            e_done  = (d == S3 + 3) ? (32'd1 << m_w) : 0;

            check("rnd gnt", 32'(b_gnt), e_gnt);
            check("rnd err", 32'(b_err), e_err);
            check("rnd done", 32'(b_done), e_done);
            check("rnd busy", 32'(b_busy), e_busy);
            check("rnd oe1", 32'(b_oe1), e_oe1);
            check("rnd oe2", 32'(b_oe2), e_oe2);
            check("rnd hold", 32'(b_hold), e_hold);
            check("rnd latch", 32'(b_latch), e_latch);
            check("inv oe onehot0", 32'($onehot0({b_oe1, b_oe2})), 1);
            check("inv latch onehot0", 32'($onehot0(b_latch)), 1);
            check("inv latch vs hold", 32'(b_latch & b_hold), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
